// File: rtl/mips_rf_pkg.sv
// Shared constants for the parametrised MIPS register file and its scoreboard.
package mips_rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR  = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for hazard detection: issue sets, writeback clears,
// issue wins a same-cycle tie, and register 0 is never busy when hardwired.
module rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // The issue is applied last so a new owner overrides a retiring writer.
  always_comb begin
    // NOTE: every always_comb output gets a full default first; a path that
    // leaves it unassigned would infer a latch.
    busy_nxt = busy;
    if (wr1_en) busy_nxt[wr1_addr] = 1'b0;
    if (wr0_en) busy_nxt[wr0_addr] = 1'b0;
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[ADDR_W'(ZERO_ADDR)] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with <= only, so every flop samples the values
    // from before the edge regardless of statement order.
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  function automatic logic busy_of(input logic [ADDR_W-1:0] a);
    logic wr_hit;
    wr_hit = (wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a);
    if (ZERO_REG != 0 && a == ADDR_W'(ZERO_ADDR))          return 1'b0;
    if (BYPASS != 0 && wr_hit && !(iss_en && iss_addr == a)) return 1'b0;
    return busy[a];
  endfunction

  always_comb begin
    rd_busy_a = busy_of(rd_addr_a);
    rd_busy_b = busy_of(rd_addr_b);
  end

endmodule

// File: rtl/regm_mp.sv
// Two-read / two-write register file with optional write bypass, hardwired
// zero register, dual-write collision flag and a busy scoreboard.
module regm_mp
  import mips_rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              wr_collide
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr0_we;
  logic              wr1_we;
  logic              same_addr;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ADDR_W'(ZERO_ADDR));
  endfunction

  // Port 0 wins a same-address collision, so port 1 is suppressed there.
  always_comb begin
    same_addr = (wr0_addr == wr1_addr);
    wr0_we    = wr0_en && !is_zero(wr0_addr);
    wr1_we    = wr1_en && !is_zero(wr1_addr) && !(wr0_en && same_addr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is reset explicitly because the register file must
      // read as all-zero immediately after reset; this keeps it in flops.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (wr0_we) regs[wr0_addr] <= wr0_data;
      if (wr1_we) regs[wr1_addr] <= wr1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_collide <= 1'b0;
    else        wr_collide <= wr0_en && wr1_en && same_addr && !is_zero(wr0_addr);
  end

  function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] a);
    if (is_zero(a))                           return '0;
    if (BYPASS != 0 && wr0_en && wr0_addr == a) return wr0_data;
    if (BYPASS != 0 && wr1_en && wr1_addr == a) return wr1_data;
    return regs[a];
  endfunction

  always_comb begin
    rd_data_a = read_mux(rd_addr_a);
    rd_data_b = read_mux(rd_addr_b);
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rd_busy_a(rd_busy_a),
    .rd_busy_b(rd_busy_b)
  );

endmodule

// File: tb/tb_regm_mp.sv
// Scoreboard bench for regm_mp: a bypassing and a non-bypassing instance share
// stimulus and are checked against an abstract register/busy model.
module tb_regm_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr_a, rd_addr_b, wr0_addr, wr1_addr, iss_addr;
  logic [31:0] wr0_data, wr1_data;
  logic        wr0_en, wr1_en, iss_en;

  logic [31:0] rda1, rdb1, rda0, rdb0;
  logic        ba1, bb1, ba0, bb0, col1, col0;

  always #5 clk = ~clk;

  regm_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) u_byp (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda1), .rd_data_b(rdb1),
    .rd_busy_a(ba1), .rd_busy_b(bb1),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .wr_collide(col1)
  );

  regm_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(1)) u_nob (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda0), .rd_data_b(rdb0),
    .rd_busy_a(ba0), .rd_busy_b(bb0),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .wr_collide(col0)
  );

  typedef struct {
    logic [31:0] da1, db1, da0, db0;
    logic        ba1, bb1, ba0, bb0, col;
  } exp_t;

  exp_t        exp_q[$];
  logic        sample_valid = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: architectural contents, busy set, pending collision flag.
  logic [31:0] m_mem  [32];
  logic        m_busy [32];
  logic        m_col;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'd0;
      m_busy[i] = 1'b0;
    end
    m_col = 1'b0;
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (a == 5'd0)                            return 32'd0;
    if (byp && wr0_en && wr0_addr == a)       return wr0_data;
    if (byp && wr1_en && wr1_addr == a)       return wr1_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    bit written, issued;
    written = (wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a);
    issued  = iss_en && iss_addr == a;
    if (a == 5'd0)                   return 1'b0;
    if (byp && written && !issued)   return 1'b0;
    return m_busy[a];
  endfunction

  // One clock: predict the outputs visible this cycle, then advance the model.
  task automatic step();
    exp_t e;
    e.da1 = exp_data(rd_addr_a, 1'b1);  e.db1 = exp_data(rd_addr_b, 1'b1);
    e.da0 = exp_data(rd_addr_a, 1'b0);  e.db0 = exp_data(rd_addr_b, 1'b0);
    e.ba1 = exp_busy(rd_addr_a, 1'b1);  e.bb1 = exp_busy(rd_addr_b, 1'b1);
    e.ba0 = exp_busy(rd_addr_a, 1'b0);  e.bb0 = exp_busy(rd_addr_b, 1'b0);
    e.col = m_col;
    exp_q.push_back(e);
    sample_valid = 1'b1;
    @(posedge clk);
    if (wr1_en) begin m_mem[wr1_addr] = wr1_data; m_busy[wr1_addr] = 1'b0; end
    if (wr0_en) begin m_mem[wr0_addr] = wr0_data; m_busy[wr0_addr] = 1'b0; end
    if (iss_en) m_busy[iss_addr] = 1'b1;
    m_mem[0]  = 32'd0;
    m_busy[0] = 1'b0;
    m_col = wr0_en && wr1_en && (wr0_addr == wr1_addr) && (wr0_addr != 5'd0);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0;
    wr0_addr = '0; wr1_addr = '0; iss_addr = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  // Monitor: compares the DUT against the oldest prediction mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          check("monitor_queue_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("byp_rd_data_a", rda1, e.da1);
          check("byp_rd_data_b", rdb1, e.db1);
          check("byp_rd_busy_a", {31'd0, ba1}, {31'd0, e.ba1});
          check("byp_rd_busy_b", {31'd0, bb1}, {31'd0, e.bb1});
          check("nob_rd_data_a", rda0, e.da0);
          check("nob_rd_data_b", rdb0, e.db0);
          check("nob_rd_busy_a", {31'd0, ba0}, {31'd0, e.ba0});
          check("nob_rd_busy_b", {31'd0, bb0}, {31'd0, e.bb0});
          check("byp_wr_collide", {31'd0, col1}, {31'd0, e.col});
          check("nob_wr_collide", {31'd0, col0}, {31'd0, e.col});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rd_addr_a = '0; rd_addr_b = '0;
    model_reset();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset then read every register in pairs.
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 5'(2 * i); rd_addr_b = 5'(2 * i + 1);
      step();
    end

    // Sequential fill through write port 0, then read back (k, k+1).
    for (int k = 0; k < 32; k++) begin
      wr0_en = 1'b1; wr0_addr = 5'(k); wr0_data = 32'(10 * k);
      rd_addr_a = 5'(k); rd_addr_b = 5'(k + 1);
      step();
      idle_inputs();
      step();
    end

    // Bypass: same-cycle write and read of register 7.
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'hDEADBEEF;
    rd_addr_a = 5'd7; rd_addr_b = 5'd8;
    step();
    idle_inputs();
    step();

    // Dual-write collision at 5, then at the zero register.
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h22;
    rd_addr_a = 5'd5; rd_addr_b = 5'd0;
    step();
    idle_inputs();
    step();
    step();
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'h22;
    step();
    idle_inputs();
    step();
    step();

    // Scoreboard: issue, load writeback clear, then set-beats-clear.
    rd_addr_a = 5'd9; rd_addr_b = 5'd0;
    iss_en = 1'b1; iss_addr = 5'd9;
    step();
    idle_inputs();
    step();
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h99;
    step();
    idle_inputs();
    step();
    iss_en = 1'b1; iss_addr = 5'd9;
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h909;
    step();
    idle_inputs();
    step();

    // Randomised traffic over a narrow address window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      wr0_en   = 1'($urandom_range(0, 1));
      wr1_en   = 1'($urandom_range(0, 1));
      iss_en   = 1'($urandom_range(0, 1));
      wr0_addr = 5'($urandom_range(0, 7));
      wr1_addr = 5'($urandom_range(0, 7));
      iss_addr = 5'($urandom_range(0, 7));
      wr0_data = $urandom;
      wr1_data = $urandom;
      rd_addr_a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rd_addr_b = 5'($urandom_range(0, 7));
      step();
    end
    idle_inputs();

    // Async reset between edges with a write pending; register 10 is busy first.
    iss_en = 1'b1; iss_addr = 5'd10;
    wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'h120;
    rd_addr_a = 5'd10; rd_addr_b = 5'd12;
    step();
    idle_inputs();
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h0BADF00D;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_byp_rd_data_a", rda1, 32'd0);
    check("rst_byp_rd_data_b", rdb1, 32'd0);
    check("rst_nob_rd_data_a", rda0, 32'd0);
    check("rst_byp_rd_busy_a", {31'd0, ba1}, 32'd0);
    check("rst_nob_rd_busy_a", {31'd0, ba0}, 32'd0);
    check("rst_wr_collide", {31'd0, col1}, 32'd0);
    #2 rst_n = 1'b1;
    #1 idle_inputs();
    @(posedge clk); #1;
    rd_addr_a = 5'd3; rd_addr_b = 5'd10;
    step();
    rd_addr_a = 5'd12; rd_addr_b = 5'd7;
    step();

    #20;
    check("scoreboard_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regm_mp.md
Name: regm_mp

Overview:
- Parametrised successor to the two-read/one-write MIPS register file.
- Adds the following:
  - configurable data width and register count
  - two write ports (ALU writeback, load writeback)
  - optional same-cycle write-to-read bypass
  - hardwired zero register
  - per-register busy scoreboard for pipeline hazard detection
- Sits in the decode stage. Reads feed the ID/EX latch; writes come from the WB stage.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W
- BYPASS, 1, 1: a write in the current cycle is forwarded to a matching read; 0: reads return stored contents only
- ZERO_REG, 1, 1: register 0 reads as 0, ignores writes and is never busy

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr_a  in  ADDR_W  read port A address
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_a  out  DATA_W  read port A data (combinational)
- rd_data_b  out  DATA_W  read port B data (combinational)
- rd_busy_a  out  1  scoreboard busy bit for rd_addr_a
- rd_busy_b  out  1  scoreboard busy bit for rd_addr_b
- wr0_en  in  1  write port 0 enable (ALU)
- wr0_addr  in  ADDR_W  write port 0 address
- wr0_data  in  DATA_W  write port 0 data
- wr1_en  in  1  write port 1 enable (load)
- wr1_addr  in  ADDR_W  write port 1 address
- wr1_data  in  DATA_W  write port 1 data
- iss_en  in  1  instruction issue; marks the destination pending
- iss_addr  in  ADDR_W  issued destination register
- wr_collide  out  1  registered one-cycle pulse: both write ports targeted the same non-zero address in the previous cycle

Behaviour:
- Reset:
  - rst_n low asynchronously clears all registers to 0, all busy bits to 0, and wr_collide to 0.
  - Effect is immediate, not at the next edge. Reset asserted mid-write discards that write.
- Write:
  - On posedge clk, a port with en=1 stores its data at its address.
  - Both enabled to different addresses: both writes occur.
  - Both enabled to the same address: port 0 wins, port 1 data is dropped, wr_collide=1 in the following cycle.
- Zero register:
  - With ZERO_REG=1, writes to address 0 are ignored, reads of address 0 return 0 regardless of bypass, busy[0] is always 0, and collisions at address 0 do not assert wr_collide.
  - With ZERO_REG=0, register 0 is ordinary.
- Read:
  - Purely combinational from the stored array; zero clock latency.
  - BYPASS=1 priority per read port:
    1. zero-register rule
    2. wr0 match
    3. wr1 match
    4. array
  - BYPASS=0: array only. A value written at edge N is visible after edge N.
- Scoreboard:
  - On posedge, iss_en sets busy[iss_addr].
  - Any enabled write clears busy[wr_addr] on either port.
  - Set and clear to the same address in the same cycle: set wins, because the new instruction owns the register.
  - rd_busy_a and rd_busy_b are combinational lookups of the busy vector.
  - With BYPASS=1, rd_busy reports 0 when a same-cycle write to that address exists and no same-cycle issue targets it.
- No other state. No X may propagate from unenabled write ports.

Decomposition:
- Shared package mips_rf_pkg:
  - defaults DATA_W_DEF=32, ADDR_W_DEF=5
  - localparam ZERO_ADDR
- Natural sub-module: rf_scoreboard. It holds the busy vector, the set/clear priority and the zero-register masking.
- regm_mp instantiates rf_scoreboard and contains the array, the write arbitration, the bypass muxes and wr_collide.

Test Plan:
1. Reset then read:
   - stimulus: rst_n=0 for 12 ns, release, read all 32 addresses in pairs
   - response: all data 0, all busy 0, wr_collide 0
2. Sequential fill:
   - stimulus: for k=0..31 write wr0 with data 10*k, then read pairs (k, k+1)
   - response: reg[k]=10*k for k≥1; reg[0]=0 with ZERO_REG=1
3. Bypass:
   - stimulus: BYPASS=1, wr0 writes addr 7 with 0xDEADBEEF while rd_addr_a=7 in the same cycle
   - response: rd_data_a=0xDEADBEEF before the edge
   - stimulus: repeat with BYPASS=0
   - response: old value before the edge, new value after it
4. Dual-write collision:
   - stimulus: wr0 (addr 5, data 0x11) and wr1 (addr 5, data 0x22) in one cycle
   - response: reg[5]=0x11, wr_collide=1 for exactly one cycle
   - stimulus: same at addr 0
   - response: reg[0]=0, no pulse
5. Scoreboard:
   - stimulus: issue addr 9
   - response: rd_busy for addr 9 is 1 next cycle
   - stimulus: wr1 to 9
   - response: busy clears next cycle
   - stimulus: issue 9 and wr0 to 9 in the same cycle
   - response: busy stays 1
6. Async reset mid-operation:
   - stimulus: after the fill, pulse rst_n low for 3 ns between clock edges with wr0_en=1
   - response: all registers and busy bits 0 immediately, pending write lost
